round_sat_pack: RTL

Integrate-and-dump accumulator and flag packer that sits upstream of the round/saturate stage. It sums `cfg_len` signed input samples and selects a 16-bit window at offset `cfg_shift`. It then emits one 20-bit annotated word per block carrying that window plus clamp, pre-saturation, round and sign flags. Input and output both use the elastic req/ack interface.

---
 rtl/round_sat_pkg.sv | 18 +
 rtl/round_sat_pack_fmt.sv | 36 +++
 rtl/round_sat_pack.sv | 131 +++++++++++++
 3 files changed

// File: rtl/round_sat_pkg.sv
// Shared definitions for the annotated round/saturate word and the
// packer's block FSM.
package round_sat_pkg;

    localparam int ROUND_SAT_W = 20;

    localparam int RS_CLAMP    = 19;
    localparam int RS_PRE_SAT  = 18;
    localparam int RS_ROUND    = 17;
    localparam int RS_SIGN     = 16;
    localparam int RS_DATA_MSB = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/round_sat_pack_fmt.sv
// Combinational formatter: selects the 16-bit window of a block sum and
// derives the clamp / pre-saturation / round / sign flags.
module round_sat_pack_fmt
    import round_sat_pkg::*;
#(
    parameter int ACC_WIDTH = 40
) (
    input  logic [ACC_WIDTH-1:0]   sum_i,
    input  logic [4:0]             shift_i,
    input  logic                   clamp_en_i,
    output logic [ROUND_SAT_W-1:0] word_o
);

    logic [ACC_WIDTH-1:0] hi;
    logic                 sign;
    logic                 rnd;
    logic                 pre_sat;

    // Arithmetic shift leaves S[MSB:s+15] sign-extended; those bits agree
    // exactly when the result is all zeros or all ones.
    assign hi      = $signed(sum_i) >>> ({1'b0, shift_i} + 6'd15);
    assign pre_sat = ~((hi == '0) | (hi == '1));
    assign sign    = sum_i[ACC_WIDTH-1];
    // Appending a zero LSB makes bit 0 of the shifted value S[s-1], or 0 at s=0.
    assign rnd     = 1'({sum_i, 1'b0} >> shift_i);

    always_comb begin
        word_o                = '0;
        word_o[RS_DATA_MSB:0] = 16'(sum_i >> shift_i);
        word_o[RS_SIGN]       = sign;
        word_o[RS_ROUND]      = rnd;
        word_o[RS_PRE_SAT]    = pre_sat;
        word_o[RS_CLAMP]      = clamp_en_i & sign;
    end

endmodule

// File: rtl/round_sat_pack.sv
// Integrate-and-dump accumulator: sums cfg_len samples per block and emits
// one annotated 20-bit word per block through a single-entry output register.
module round_sat_pack
    import round_sat_pkg::*;
#(
    parameter int T_0_DAT_WIDTH = 32,
    parameter int ACC_WIDTH     = 40,
    parameter int I_0_DAT_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [T_0_DAT_WIDTH-1:0] t_0_dat,
    input  logic                     t_0_req,
    output logic                     t_0_ack,
    output logic [I_0_DAT_WIDTH-1:0] i_0_dat,
    output logic                     i_0_req,
    input  logic                     i_0_ack,
    input  logic [7:0]               cfg_len,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_clamp
);

    localparam int SMAX = ACC_WIDTH - 16;
    localparam logic [4:0] SHIFT_MAX = (SMAX > 31) ? 5'd31 : 5'(SMAX);

    rsp_state_e             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [7:0]             count_q, count_d;
    logic [7:0]             len_q, len_d;
    logic [4:0]             shift_q, shift_d;
    logic                   clamp_q, clamp_d;
    logic [ROUND_SAT_W-1:0] odat_q;
    logic                   oreq_q;

    logic                   accept;
    logic                   done;
    logic [ACC_WIDTH-1:0]   x_ext;
    logic [ACC_WIDTH-1:0]   sum_c;
    logic [ROUND_SAT_W-1:0] word_c;

    assign t_0_ack = ~oreq_q | i_0_ack;
    assign accept  = t_0_req & t_0_ack;
    assign x_ext   = {{(ACC_WIDTH-T_0_DAT_WIDTH){t_0_dat[T_0_DAT_WIDTH-1]}}, t_0_dat};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        shift_d = shift_q;
        clamp_d = clamp_q;
        done    = 1'b0;
        sum_c   = acc_q + x_ext;
        case (state_q)
            ST_IDLE: begin
                sum_c = x_ext;
                if (accept) begin
                    len_d   = (cfg_len == 8'd0) ? 8'd1 : cfg_len;
                    shift_d = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;
                    clamp_d = cfg_clamp;
                    acc_d   = x_ext;
                    if (len_d == 8'd1) begin
                        done    = 1'b1;
                        count_d = 8'd0;
                    end else begin
                        count_d = 8'd1;
                        state_d = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (accept) begin
                    acc_d = sum_c;
                    if (count_q + 8'd1 == len_q) begin
                        done    = 1'b1;
                        count_d = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fed with the next-state config so a len=1 block formats with the
    // values latched on its own beat.
    round_sat_pack_fmt #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_fmt (
        .sum_i      (sum_c),
        .shift_i    (shift_d),
        .clamp_en_i (clamp_d),
        .word_o     (word_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= 8'd0;
            len_q   <= 8'd1;
            shift_q <= 5'd0;
            clamp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            clamp_q <= clamp_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            odat_q <= '0;
            oreq_q <= 1'b0;
        end else if (done) begin
            odat_q <= word_c;
            oreq_q <= 1'b1;
        end else if (i_0_ack) begin
            oreq_q <= 1'b0;
        end
    end

    assign i_0_dat = odat_q;
    assign i_0_req = oreq_q;

endmodule
